// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage register.
// pipe_state_t encodes how many entries the stage currently holds:
//   PS_EMPTY - nothing held, out_valid low
//   PS_ONE   - main entry valid
//   PS_FULL  - main and skid entries valid, in_ready low
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_ONE,
        PS_FULL
    } pipe_state_t;

endpackage

// File: rtl/n_bit_reg_wclr.sv
// Generic n-bit register with write enable and synchronous clear.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset, loads RESET_VALUE
//   clear   - synchronous clear, loads CLR_VALUE; wins over wen
//   wen     - write enable, loads data_i
//   data_i  - next value
//   data_o  - registered value
module n_bit_reg_wclr #(
    parameter int             n           = 32,
    parameter logic [n-1:0]   RESET_VALUE = '0,
    parameter logic [n-1:0]   CLR_VALUE   = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         wen,
    input  logic [n-1:0] data_i,
    output logic [n-1:0] data_o
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_o <= RESET_VALUE;
        end else if (clear) begin
            data_o <= CLR_VALUE;
        end else if (wen) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer, giving one transfer per cycle under streaming and absorbing one
// extra beat when downstream stalls. All outputs are decoded from registers
// only, so there is no combinational input-to-output path.
// Ports:
//   clk       - rising-edge clock
//   reset_n   - asynchronous active-low reset
//   flush     - synchronous kill of all held entries (beats any transfer)
//   in_valid  - upstream presents data_i
//   in_ready  - stage can accept this cycle
//   data_i    - upstream payload
//   out_valid - data_o is valid
//   out_ready - downstream accepts this cycle
//   data_o    - head payload (main entry)
//   count     - entries held: 0, 1 or 2
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count
);

    pipe_state_t      state;
    pipe_state_t      state_next;
    logic             accept;
    logic             deliver;
    logic             main_wen;
    logic             skid_wen;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    // Next-state and entry-write decode. Flush is applied separately: it
    // forces the state to EMPTY and clears both entries inside the
    // registers, so the writes decoded here are simply overridden.
    always_comb begin
        state_next = state;
        main_wen   = 1'b0;
        skid_wen   = 1'b0;
        main_d     = data_i;
        case (state)
            PS_EMPTY: begin
                if (accept) begin
                    state_next = PS_ONE;
                    main_wen   = 1'b1;
                end
            end
            PS_ONE: begin
                if (accept && deliver) begin
                    main_wen = 1'b1;
                end else if (accept) begin
                    state_next = PS_FULL;
                    skid_wen   = 1'b1;
                end else if (deliver) begin
                    state_next = PS_EMPTY;
                end
            end
            PS_FULL: begin
                // in_ready is low here, so only a delivery can happen;
                // the skid entry moves up to the head.
                if (deliver) begin
                    state_next = PS_ONE;
                    main_wen   = 1'b1;
                    main_d     = skid_q;
                end
            end
            default: begin
                state_next = PS_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PS_EMPTY;
        end else if (flush) begin
            state <= PS_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    n_bit_reg_wclr #(
        .n           (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .CLR_VALUE   (FLUSH_VALUE)
    ) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .wen     (main_wen),
        .data_i  (main_d),
        .data_o  (main_q)
    );

    n_bit_reg_wclr #(
        .n           (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .CLR_VALUE   (FLUSH_VALUE)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .wen     (skid_wen),
        .data_i  (data_i),
        .data_o  (skid_q)
    );

    always_comb begin
        out_valid = (state != PS_EMPTY);
        in_ready  = (state != PS_FULL);
        data_o    = main_q;
        case (state)
            PS_ONE:  count = 2'd1;
            PS_FULL: count = 2'd2;
            default: count = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int          W    = 32;
    localparam logic [31:0] FVAL = 32'h0000_0013;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_i;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  data_o;
    logic [1:0]    count;

    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  sb[$];

    pipe_stage_reg #(
        .WIDTH       (W),
        .RESET_VALUE (32'h0),
        .FLUSH_VALUE (FVAL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer the current in_valid/data_i for one edge, recording the beat in
    // the scoreboard when the stage takes it.
    task automatic offer_tick();
        if (in_valid && in_ready && !flush) sb.push_back(data_i);
        tick();
    endtask

    // Monitor: a delivery happens at the next rising edge whenever
    // out_valid and out_ready are both high; compare the head against
    // the oldest expected beat.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h expected none", data_o);
            end else begin
                check("sb_data", data_o, sb.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_i    = '0;
        #12;
        reset_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_data_o",    data_o,         32'h0);
        tick();

        // Streaming: one beat per cycle, no bubbles
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            in_valid = 1'b1;
            data_i   = 32'(v);
            offer_tick();
            check("stream_count", 32'(count), 32'd1);
            check("stream_data",  data_o,     32'(v));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_count", 32'(count), 32'd0);

        // Back-pressure: A, B fill the stage, C is refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_i    = 32'hA;
        offer_tick();
        data_i    = 32'hB;
        offer_tick();
        check("bp_count",    32'(count),    32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_data",     data_o,        32'hA);
        data_i = 32'hC;
        offer_tick();
        check("bp_hold_count", 32'(count), 32'd2);
        check("bp_hold_data",  data_o,     32'hA);
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            logic took;
            took = in_valid && in_ready;
            offer_tick();
            if (took) in_valid = 1'b0;
            if (!in_valid && !out_valid) done = 1'b1;
        end
        check("bp_drained", 32'(done), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Flush while FULL, with a beat offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_i    = 32'hA;
        offer_tick();
        data_i    = 32'hB;
        offer_tick();
        check("fl_pre_count", 32'(count), 32'd2);
        flush  = 1'b1;
        data_i = 32'hC;
        sb.delete();
        offer_tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_count",     32'(count),     32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        check("fl_data",      data_o,         FVAL);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_no_c", 32'(out_valid), 32'd0);

        // Simultaneous accept and deliver in ONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_i    = 32'h1111_0000;
        offer_tick();
        check("ad_x_data", data_o, 32'h1111_0000);
        out_ready = 1'b1;
        data_i    = 32'h2222_0000;
        offer_tick();
        in_valid = 1'b0;
        check("ad_y_data",  data_o,     32'h2222_0000);
        check("ad_count",   32'(count), 32'd1);
        tick();
        check("ad_empty", 32'(count), 32'd0);
        check("ad_sb_empty", 32'(sb.size()), 32'd0);

        // Reset pulse in FULL: outputs clear before the next edge
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_i    = 32'h5;
        offer_tick();
        data_i    = 32'h6;
        offer_tick();
        in_valid = 1'b0;
        check("mr_pre_count", 32'(count), 32'd2);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mr_count",     32'(count),     32'd0);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd1);
        check("mr_data",      data_o,         32'h0);
        #4;
        reset_n = 1'b1;
        tick();
        check("mr_after_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
